// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl
// Player-input conditioner for the Tetris top level.
//  - Joystick X-axis ADC samples drive a CENTER/LEFT/RIGHT zone FSM with
//    hysteresis on the exits. Entering LEFT or RIGHT fires a one-cycle move
//    pulse. Holding the zone repeats the pulse after DAS_CYC cycles, then
//    every ARR_CYC cycles (delayed auto-shift plus auto-repeat).
//  - NUM_BTN active-low pushbuttons are synchronised and debounced into
//    clean levels, and a one-cycle pulse is produced on each press.
// Optional feature macro: TETRIS_INPUT_ADC_FILTER_EN
//   When defined, the zone compare uses the average of the last 4 valid
//   samples. The FSM stays in CENTER until 4 samples have arrived.
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   adc_value  in   [ADC_W]   joystick X sample, unsigned
//   adc_valid  in   adc_value qualifier
//   btn_n      in   [NUM_BTN] raw pushbuttons, low = pressed
//   move_left  out  one-cycle move-left pulse
//   move_right out  one-cycle move-right pulse
//   dir_state  out  [2]       00 CENTER, 01 LEFT, 10 RIGHT
//   btn_level  out  [NUM_BTN] debounced level, 1 = pressed
//   btn_press  out  [NUM_BTN] one-cycle pulse on each debounced press
module tetris_input_ctrl #(
  parameter int ADC_W        = 12,
  parameter int LEFT_TH      = 1200,
  parameter int RIGHT_TH     = 2100,
  parameter int HYST         = 64,
  parameter int NUM_BTN      = 2,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int DAS_CYC      = 10000000,
  parameter int ARR_CYC      = 2500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADC_W-1:0]   adc_value,
  input  logic               adc_valid,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic               move_left,
  output logic               move_right,
  output logic [1:0]         dir_state,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press
);

  if (DAS_CYC < 1 || ARR_CYC < 1) begin : g_bad_repeat
    $fatal(1, "tetris_input_ctrl: DAS_CYC and ARR_CYC must be >= 1");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $fatal(1, "tetris_input_ctrl: DEBOUNCE_CYC must be >= 1");
  end
  if (LEFT_TH + HYST > RIGHT_TH - HYST) begin : g_bad_thresholds
    $fatal(1, "tetris_input_ctrl: hysteresis bands overlap");
  end

  typedef enum logic [1:0] {
    ZONE_CENTER = 2'b00,
    ZONE_LEFT   = 2'b01,
    ZONE_RIGHT  = 2'b10
  } zone_t;

  // Compare thresholds carry one extra bit so that enter/exit points near
  // the top of the ADC range cannot be truncated.
  localparam logic [ADC_W:0] L_ENTER = (ADC_W+1)'(LEFT_TH);
  localparam logic [ADC_W:0] L_EXIT  = (ADC_W+1)'(LEFT_TH + HYST);
  localparam logic [ADC_W:0] R_ENTER = (ADC_W+1)'(RIGHT_TH);
  localparam logic [ADC_W:0] R_EXIT  = (ADC_W+1)'(RIGHT_TH - HYST);

  localparam int RPT_MAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DAS_LAST = RPT_W'(DAS_CYC - 1);
  localparam logic [RPT_W-1:0] ARR_LAST = RPT_W'(ARR_CYC - 1);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC);

  zone_t            zone, zone_next;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_next;
  logic             das_done, das_done_next;
  logic             left_next, right_next;
  logic [RPT_W-1:0] rpt_last;
  logic [ADC_W-1:0] sample;
  logic [ADC_W:0]   sample_x;
  logic             eval;

`ifdef TETRIS_INPUT_ADC_FILTER_EN
  // The three previous valid samples plus the current one are averaged.
  // Decisions wait until the history holds real samples, so the first
  // decision is made in the same cycle the 4th sample is presented.
  logic [ADC_W-1:0] hist [3];
  logic [1:0]       fill;
  logic [ADC_W+1:0] sum;

  always_comb begin
    sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, adc_value};
  end

  assign sample = sum[ADC_W+1:2];
  assign eval   = adc_valid && (fill == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
      fill    <= 2'd0;
    end else if (adc_valid) begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= adc_value;
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
    end
  end
`else
  assign sample = adc_value;
  assign eval   = adc_valid;
`endif

  assign sample_x = {1'b0, sample};

  // Zone decision plus repeat timing. The repeat counter restarts on every
  // zone change. It counts up to the current limit (DAS first, then ARR)
  // and reloads on each repeat pulse, so it can never wrap.
  always_comb begin
    zone_next     = zone;
    rpt_cnt_next  = rpt_cnt;
    das_done_next = das_done;
    left_next     = 1'b0;
    right_next    = 1'b0;
    rpt_last      = das_done ? ARR_LAST : DAS_LAST;

    if (eval) begin
      unique case (zone)
        ZONE_CENTER: begin
          if (sample_x < L_ENTER)      zone_next = ZONE_LEFT;
          else if (sample_x > R_ENTER) zone_next = ZONE_RIGHT;
        end
        ZONE_LEFT: begin
          if (sample_x > R_ENTER)       zone_next = ZONE_RIGHT;
          else if (sample_x >= L_EXIT)  zone_next = ZONE_CENTER;
        end
        ZONE_RIGHT: begin
          if (sample_x < L_ENTER)       zone_next = ZONE_LEFT;
          else if (sample_x <= R_EXIT)  zone_next = ZONE_CENTER;
        end
        default: zone_next = ZONE_CENTER;
      endcase
    end

    if (zone_next != zone) begin
      rpt_cnt_next  = '0;
      das_done_next = 1'b0;
      left_next     = (zone_next == ZONE_LEFT);
      right_next    = (zone_next == ZONE_RIGHT);
    end else if (zone != ZONE_CENTER) begin
      if (rpt_cnt == rpt_last) begin
        rpt_cnt_next  = '0;
        das_done_next = 1'b1;
        left_next     = (zone == ZONE_LEFT);
        right_next    = (zone == ZONE_RIGHT);
      end else begin
        rpt_cnt_next = rpt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zone       <= ZONE_CENTER;
      rpt_cnt    <= '0;
      das_done   <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      zone       <= zone_next;
      rpt_cnt    <= rpt_cnt_next;
      das_done   <= das_done_next;
      move_left  <= left_next;
      move_right <= right_next;
    end
  end

  assign dir_state = zone;

  // Button conditioning. A level change is accepted only after the
  // synchronised input has differed from the level on DEBOUNCE_CYC
  // consecutive counted edges. Any return to agreement restarts the count.
  logic [NUM_BTN-1:0] sync1, sync2;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        btn_press[i] <= 1'b0;
        if (sync2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= ~btn_level[i];
          btn_press[i] <= ~btn_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
